// File: rtl/sequential_multiplier.sv
// Unsigned WIDTH x WIDTH shift-add multiplier producing a 2*WIDTH product on hi/lo.
// Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH+1 (fixed).
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE (back-to-back).
module sequential_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               last_step;

    // Counter reaching WIDTH means all shift-add steps are done; this edge only publishes.
    assign last_step = (cnt == CW'(WIDTH));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_step ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
